// File: rtl/data_mem_unit.sv
// data_mem_unit: multi-cycle word data memory with req/resp handshake, wait states and error flagging
//   clk, rst              clock, synchronous active-high reset
//   req_valid / req_ready request handshake; accept when both high at a rising edge
//   mem_read / mem_write  load / store select (exactly one must be set)
//   addr, wdata           byte address and store data, latched on accept
//   rdata                 load data, valid with resp_valid and held afterwards
//   resp_valid, err       one-cycle completion pulse and its reject flag
//   busy                  unit not idle (CPU stall source)
module data_mem_unit #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        resp_valid,
  output logic        err,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
  localparam logic [3:0] WC_M1 = 4'(WAIT_CYCLES - 1);
  state_t                state_q, state_d;
  logic [3:0]            count_q, count_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d, rdata_q, rdata_d;
  logic                  rd_q, rd_d, wr_q, wr_d, err_q, err_d;
  logic [31:0]           mem [2**ADDR_WIDTH];
  logic                  accept, bad, mem_we;
  // RESP also accepts, so a held request is taken on the RESP closing edge
  assign req_ready  = state_q == IDLE || state_q == RESP;
  assign accept     = req_valid && req_ready;
  assign bad        = addr[1:0] != 2'b00 || addr[31:ADDR_WIDTH+2] != '0 || mem_read == mem_write;
  assign mem_we     = state_q == ACCESS && wr_q && !err_q && !rst;
  assign resp_valid = state_q == RESP;
  assign err        = resp_valid && err_q;
  assign busy       = state_q != IDLE;
  assign rdata      = rdata_q;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    if (accept) begin
      state_d = WAIT_CYCLES > 0 ? WAIT : ACCESS;
      count_d = WAIT_CYCLES > 0 ? WC_M1 : 4'd0;
      idx_d   = addr[ADDR_WIDTH+1:2];
      wdata_d = wdata;
      rd_d    = mem_read;
      wr_d    = mem_write;
      err_d   = bad;
    end else begin
      case (state_q)
        WAIT: begin
          state_d = count_q == 4'd0 ? ACCESS : WAIT;
          count_d = count_q == 4'd0 ? 4'd0 : count_q - 4'd1;
        end
        ACCESS: begin
          state_d = RESP;
          rdata_d = err_q ? 32'd0 : rd_q ? mem[idx_q] : rdata_q;
        end
        RESP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end
  // array has no reset; contents survive rst
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: randomized reference-model bench for data_mem_unit (WAIT_CYCLES=2 and 0 builds)
module tb_data_mem_unit;
  logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  int          sel = 0;
  logic        rdy0, rdy1, rv0, rv1, e0, e1, b0, b1;
  logic [31:0] rd0, rd1;
  logic        ready, resp, err, busy;
  logic [31:0] rdata;
  int          checks = 0, errors = 0;
  logic [31:0] ref_mem [2][1024];
  logic [31:0] ref_rdata [2];
  always #5 clk = ~clk;
  data_mem_unit #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel == 0), .req_ready(rdy0),
    .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wdata(wdata),
    .rdata(rd0), .resp_valid(rv0), .err(e0), .busy(b0));
  data_mem_unit #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel == 1), .req_ready(rdy1),
    .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wdata(wdata),
    .rdata(rd1), .resp_valid(rv1), .err(e1), .busy(b1));
  assign ready = sel == 1 ? rdy1 : rdy0;
  assign resp  = sel == 1 ? rv1 : rv0;
  assign err   = sel == 1 ? e1 : e0;
  assign busy  = sel == 1 ? b1 : b0;
  assign rdata = sel == 1 ? rd1 : rd0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (sel=%0d) got=%h exp=%h", tag, sel, got, exp);
    end
  endtask
  task automatic ref_apply(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           output logic e);
    e = a[1:0] != 2'b00 || a[31:12] != 20'd0 || rd == wr;
    if (!e && wr) ref_mem[sel][a[11:2]] = wd;
    ref_rdata[sel] = e ? 32'd0 : rd ? ref_mem[sel][a[11:2]] : ref_rdata[sel];
  endtask
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input bit hold);
    int n = 0;
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = wd; req_valid = 1'b1;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) begin
      req_valid = 1'b0;
      mem_read = 1'($urandom); mem_write = 1'($urandom); addr = $urandom; wdata = $urandom;
    end
  endtask
  task automatic wait_resp(input string tag, input logic e, input logic [31:0] r);
    int n = 0;
    while (!resp && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), sel == 1 ? 32'd1 : 32'd3);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, e});
    chk({tag, "_rdata"}, rdata, r);
  endtask
  task automatic xact(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd);
    logic e;
    ref_apply(rd, wr, a, wd, e);
    issue(rd, wr, a, wd, 1'b0);
    wait_resp(tag, e, ref_rdata[sel]);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {31'd0, resp}, 32'd0);
    chk({tag, "_err_idle"}, {31'd0, err}, 32'd0);
  endtask
  initial begin
    logic        ea, eb;
    logic [31:0] ra, rb, old, a;
    logic        rd, wr;
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_resp", {31'd0, resp}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
    end
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int i = 0; i < 64; i++) xact("init", 1'b0, 1'b1, 32'(i * 4), $urandom);
      xact("s1_store", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      xact("s1_load", 1'b1, 1'b0, 32'h10, 32'h0);
      chk("s1_value", rdata, 32'hDEADBEEF);
    end
    sel = 0;
    xact("s2_misal_ld", 1'b1, 1'b0, 32'h13, 32'h0);
    old = ref_mem[0][8];
    xact("s2_misal_st", 1'b0, 1'b1, 32'h22, 32'hCAFEF00D);
    xact("s2_reload", 1'b1, 1'b0, 32'h20, 32'h0);
    chk("s2_old", rdata, old);
    xact("s3_range", 1'b1, 1'b0, 32'h1000, 32'h0);
    xact("s3_both", 1'b1, 1'b1, 32'h20, 32'h55555555);
    xact("s3_reload", 1'b1, 1'b0, 32'h20, 32'h0);
    chk("s3_old", rdata, old);
    ref_apply(1'b0, 1'b1, 32'h30, 32'hA5A5_0F0F, ea);
    ra = ref_rdata[0];
    issue(1'b0, 1'b1, 32'h30, 32'hA5A5_0F0F, 1'b1);
    mem_read = 1'b1; mem_write = 1'b0; addr = 32'h30; wdata = 32'h1111_2222;
    ref_apply(1'b1, 1'b0, 32'h30, 32'h1111_2222, eb);
    rb = ref_rdata[0];
    wait_resp("s4_first", ea, ra);
    chk("s4_ready_in_resp", {31'd0, ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("s4_busy_2nd", {31'd0, busy}, 32'd1);
    wait_resp("s4_second", eb, rb);
    chk("s4_value", rdata, 32'hA5A5_0F0F);
    @(posedge clk);
    #1;
    old = ref_mem[0][16];
    issue(1'b0, 1'b1, 32'h40, 32'h12345678, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("s5_ready", {31'd0, ready}, 32'd1);
    chk("s5_busy", {31'd0, busy}, 32'd0);
    chk("s5_resp", {31'd0, resp}, 32'd0);
    rst = 1'b0;
    ref_rdata[0] = '0;
    ref_rdata[1] = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("s5_no_resp", {31'd0, resp}, 32'd0);
    end
    xact("s5_reload", 1'b1, 1'b0, 32'h40, 32'h0);
    chk("s5_old", rdata, old);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int i = 0; i < 80; i++) begin
        int k, op;
        k = $urandom_range(0, 9);
        op = $urandom_range(0, 9);
        a = {22'd0, 6'($urandom_range(0, 63)), 2'b00};
        if (k == 0) a[1:0] = 2'($urandom_range(1, 3));
        if (k == 1) a = a | (32'd1 << $urandom_range(12, 31));
        rd = op == 0 || op >= 6;
        wr = op == 0 || (op >= 2 && op <= 5);
        xact("rand", rd, wr, a, $urandom);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
